axil_mem_bridge: RTL and testbench
==================================

Name: axil_mem_bridge

Overview:
- AXI4-Lite slave that drives the byte-wide debug/load port of the data memory (mem_en/mem_we/mem_addr/mem_din/mem_dout).
- The host loads programs and data, and reads back results, with 32-bit AXI-Lite accesses.
- Each word access is serialized into four byte accesses, little-endian, in the AXI clock domain.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_MEM_LEN, 12, log2 of data memory window in bytes (4 KiB).
- READ_LAT, 2, cycles from mem_en (read) to valid mem_dout; 1..4 supported.

Ports:
- clk  in  1  bridge/AXI clock; also drives memory debug port clock.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1;  s_awready  out  1
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes.
- s_wvalid  in  1;  s_wready  out  1
- s_bresp  out  2;  s_bvalid  out  1;  s_bready  in  1
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1;  s_arready  out  1
- s_rdata  out  32;  s_rresp  out  2;  s_rvalid  out  1;  s_rready  in  1
- mem_en  out  1  byte access enable.
- mem_we  out  1  byte write enable.
- mem_addr  out  64  byte address, zero-extended.
- mem_din  out  8  write byte.
- mem_dout  in  8  read byte, valid READ_LAT cycles after a read issue.

Behaviour:
- Reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, mem_en/mem_we 0, mem_addr/mem_din 0, state IDLE, holding flags clear. Reset mid-transaction aborts it immediately with no response generated.
- Word base: addr[1:0] ignored (forced 0). Byte i lives at base+i, from data bits [8i+7:8i].
- Range: base >= 2^DATA_MEM_LEN -> SLVERR (2'b10), no memory access. Otherwise OKAY (2'b00).
- States: IDLE, WR_BYTES, WR_RESP, RD_ISSUE, RD_DRAIN, RD_RESP.
- IDLE, write capture:
  - awready=1 while no AW is held; wready=1 while no W is held.
  - AW and W may arrive in either order or in the same cycle; each is captured into a holding register.
- IDLE, read accept: arready=1 only when neither AW nor W is held.
- Priority: if AW+W are both held and arvalid is high in the same cycle, the write wins.
- WR_BYTES:
  - Iterates i=0..3, one cycle per byte.
  - mem_en=mem_we=wstrb[i], mem_addr=base+i, mem_din=byte i.
  - Bytes with a 0 strobe idle the port for that cycle but still take the cycle.
  - Always 4 cycles, then WR_RESP. An error write skips WR_BYTES.
- WR_RESP: bvalid=1 until bready. Then clear holding flags and return to IDLE.
- RD_ISSUE:
  - 4 consecutive cycles with mem_en=1, mem_we=0, mem_addr=base+i.
  - An internal READ_LAT-deep valid shift register tags byte index.
- RD_DRAIN: waits until all 4 bytes are captured into rdata[8i+7:8i].
- Read latency: AR handshake to rvalid = 1 + 4 + READ_LAT cycles. An error read goes straight to RD_RESP with rdata=0.
- RD_RESP: rvalid=1, with rdata/rresp stable until rready, then IDLE.
- Only one transaction is outstanding; no ready is asserted outside IDLE.
- mem_en is never high outside WR_BYTES/RD_ISSUE.
- Address wrap: base+i never crosses the window, because base is aligned.

Optional Feature:
- Macro: AXIL_MEM_BRIDGE_ADDR_CHECK_EN.
- Defined: range check active as above; out-of-range accesses return SLVERR and do not touch memory.
- Undefined: no range check; mem_addr uses only addr[DATA_MEM_LEN-1:2] with upper bits zeroed, so accesses alias modulo 2^DATA_MEM_LEN. bresp/rresp are always OKAY.

Test Plan:
- AW 0x10 and W 0xDEADBEEF/strb 0xF in the same cycle -> four mem writes: 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE; bvalid with OKAY.
- W before AW by 3 cycles, addr 0x23, strb 0x5, data 0x11223344 -> writes only 0x20=44 and 0x22=22; no mem_en in byte cycles 1 and 3.
- Read 0x10 after the first test, READ_LAT=2, rready held low 5 cycles -> rvalid at cycle 7 after AR handshake; rdata=0xDEADBEEF held stable until rready.
- Read 0x2000 with check enabled -> SLVERR, rdata=0, mem_en never asserted. With check disabled -> aliases 0x000, OKAY.
- AW+W held and arvalid in the same cycle -> write completes first; arready asserts only after bready is accepted.
- Assert rst in RD_ISSUE byte 2 -> all outputs 0 next edge. A following read of 0x10 returns correct data.

Source files
------------

// File: rtl/axil_mem_bridge.sv
// axil_mem_bridge: AXI4-Lite slave serialising 32-bit word accesses onto a byte-wide memory debug port.
// Ports: clk/rst (async active-high); AXI-Lite s_aw*/s_w*/s_b*/s_ar*/s_r* slave channels;
// mem_en/mem_we/mem_addr/mem_din drive the byte port, mem_dout returns read bytes READ_LAT cycles after issue.
// Optional: define AXIL_MEM_BRIDGE_ADDR_CHECK_EN to answer out-of-window accesses with SLVERR;
// otherwise addresses alias modulo 2^DATA_MEM_LEN and responses are always OKAY.
module axil_mem_bridge #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_MEM_LEN = 12,
  parameter int READ_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [63:0]           mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);
  typedef enum logic [2:0] {IDLE, WR_BYTES, WR_RESP, RD_ISSUE, RD_DRAIN, RD_RESP} state_t;
  state_t state;
  logic live, aw_held, w_held, err;
  logic [61:0] wbase, aw_word, ar_word;
  logic [31:0] hold_data;
  logic [3:0] hold_strb;
  logic [1:0] idx, nxt;
  logic [READ_LAT-1:0] pv;
  logic [1:0] pi [READ_LAT];
  logic aw_err, ar_err, unused;
`ifdef AXIL_MEM_BRIDGE_ADDR_CHECK_EN
  assign aw_err  = |s_awaddr[ADDR_WIDTH-1:DATA_MEM_LEN];
  assign ar_err  = |s_araddr[ADDR_WIDTH-1:DATA_MEM_LEN];
  assign aw_word = 62'(s_awaddr[ADDR_WIDTH-1:2]);
  assign ar_word = 62'(s_araddr[ADDR_WIDTH-1:2]);
  assign unused  = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
  assign aw_err  = 1'b0;
  assign ar_err  = 1'b0;
  assign aw_word = 62'(s_awaddr[DATA_MEM_LEN-1:2]);
  assign ar_word = 62'(s_araddr[DATA_MEM_LEN-1:2]);
  assign unused  = ^{s_awaddr[1:0], s_araddr[1:0],
                     s_awaddr[ADDR_WIDTH-1:DATA_MEM_LEN], s_araddr[ADDR_WIDTH-1:DATA_MEM_LEN]};
`endif
  assign nxt = idx + 2'd1;
  // live keeps every ready low while reset is held; arready also yields to a write
  // presented in the same cycle so the write always wins.
  assign s_awready = live && state == IDLE && !aw_held;
  assign s_wready  = live && state == IDLE && !w_held;
  assign s_arready = live && state == IDLE && !aw_held && !w_held && !s_awvalid && !s_wvalid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      err       <= 1'b0;
      wbase     <= '0;
      hold_data <= '0;
      hold_strb <= '0;
      idx       <= '0;
      pv        <= '0;
      for (int j = 0; j < READ_LAT; j++) pi[j] <= '0;
      s_bresp   <= '0;
      s_bvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= '0;
      s_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      live <= 1'b1;
      // read-tag pipeline: each issued read byte emerges READ_LAT edges later with its lane index
      for (int j = READ_LAT - 1; j > 0; j--) begin
        pv[j] <= pv[j-1];
        pi[j] <= pi[j-1];
      end
      pv[0] <= mem_en && !mem_we;
      pi[0] <= mem_addr[1:0];
      if (pv[READ_LAT-1]) s_rdata[8*pi[READ_LAT-1] +: 8] <= mem_dout;
      case (state)
        IDLE: begin
          if (s_awvalid && s_awready) begin
            aw_held <= 1'b1;
            wbase   <= aw_word;
            err     <= aw_err;
          end
          if (s_wvalid && s_wready) begin
            w_held    <= 1'b1;
            hold_data <= s_wdata;
            hold_strb <= s_wstrb;
          end
          if (aw_held && w_held) begin
            idx      <= '0;
            mem_addr <= {wbase, 2'b00};
            mem_din  <= hold_data[7:0];
            mem_en   <= hold_strb[0] && !err;
            mem_we   <= hold_strb[0] && !err;
            s_bvalid <= err;
            s_bresp  <= err ? 2'b10 : 2'b00;
            state    <= err ? WR_RESP : WR_BYTES;
          end else if (s_arvalid && s_arready) begin
            idx      <= '0;
            mem_addr <= {ar_word, 2'b00};
            mem_en   <= !ar_err;
            mem_we   <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= ar_err ? 2'b10 : 2'b00;
            s_rvalid <= ar_err;
            state    <= ar_err ? RD_RESP : RD_ISSUE;
          end
        end
        WR_BYTES: begin
          if (idx == 2'd3) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            s_bvalid <= 1'b1;
            state    <= WR_RESP;
          end else begin
            idx      <= nxt;
            mem_addr <= mem_addr + 64'd1;
            mem_din  <= hold_data[8*nxt +: 8];
            mem_en   <= hold_strb[nxt];
            mem_we   <= hold_strb[nxt];
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (idx == 2'd3) begin
            mem_en <= 1'b0;
            state  <= RD_DRAIN;
          end else begin
            idx      <= nxt;
            mem_addr <= mem_addr + 64'd1;
          end
        end
        RD_DRAIN: begin
          if (pv == '0) begin
            s_rvalid <= 1'b1;
            state    <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_mem_bridge.sv
// tb_axil_mem_bridge: directed self-checking bench for axil_mem_bridge with a READ_LAT=2 byte memory model.
module tb_axil_mem_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0] s_wstrb = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic mem_en, mem_we;
  logic [63:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] mem [4096];
  logic [7:0] rd1 = '0, rd2 = '0;
  int en_cnt = 0, wr_cnt = 0, hi_cnt = 0;
  int vectors = 0, miscompares = 0;

  axil_mem_bridge #(.ADDR_WIDTH(32), .DATA_MEM_LEN(12), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_din;
    rd1 <= mem[mem_addr[11:0]];
    rd2 <= rd1;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
    if (mem_en && mem_addr[63:12] != '0) hi_cnt <= hi_cnt + 1;
  end
  assign mem_dout = rd2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0;
    w_done = 0;
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
    if (gap == 0) begin s_awvalid = 1'b1; s_awaddr = a; end
    for (int n = 0; n < 60 && !(aw_done && w_done); n++) begin
      #1;
      aw_hs = s_awvalid && s_awready;
      w_hs = s_wvalid && s_wready;
      @(negedge clk);
      if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; s_wvalid = 1'b0; end
      if (gap > 0 && n + 1 == gap) begin s_awvalid = 1'b1; s_awaddr = a; end
    end
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n;
    n = 0;
    while (!s_bvalid && n < 60) begin @(negedge clk); n++; end
    chk("b_valid", s_bvalid, 1'b1);
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int gap, input logic [1:0] exp_resp);
    logic [1:0] r;
    send_write(a, d, s, gap);
    wait_b(r);
    chk(tag, r, exp_resp);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output bit stable);
    bit hs;
    hs = 0;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = a;
    for (int n = 0; n < 60 && !hs; n++) begin
      #1;
      hs = s_arready;
      @(negedge clk);
    end
    s_arvalid = 1'b0;
    chk("ar_accept", hs, 1'b1);
    lat = 0;
    while (!s_rvalid && lat < 60) begin @(negedge clk); lat++; end
    d = s_rdata;
    r = s_rresp;
    stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!s_rvalid || s_rdata !== d || s_rresp !== r) stable = 0;
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int lat, e0, w0, n;
    bit stable, hs, ar_seen, rv_seen;

    repeat (3) @(negedge clk);
    chk("reset_outs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
                       s_rdata, mem_en, mem_we, mem_din}, 64'd0);
    chk("reset_addr", mem_addr, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_readies", {s_awready, s_wready, s_arready}, 3'b111);

    do_write("pre_000", 32'h000, 32'h04030201, 4'hF, 0, 2'b00);
    do_write("pre_020", 32'h020, 32'h55555555, 4'hF, 0, 2'b00);
    do_write("pre_ffc", 32'hFFC, 32'hA4A3A2A1, 4'hF, 0, 2'b00);

    w0 = wr_cnt;
    do_write("wr_same_cycle_bresp", 32'h010, 32'hDEADBEEF, 4'hF, 0, 2'b00);
    chk("wr_same_cycle_mem", word_at(12'h010), 32'hDEADBEEF);
    chk("wr_same_cycle_cnt", wr_cnt - w0, 4);

    w0 = wr_cnt;
    e0 = en_cnt;
    do_write("wr_w_first_bresp", 32'h023, 32'h11223344, 4'h5, 3, 2'b00);
    chk("wr_w_first_mem", word_at(12'h020), 32'h55225544);
    chk("wr_w_first_wr_cnt", wr_cnt - w0, 2);
    chk("wr_w_first_en_cnt", en_cnt - e0, 2);

    do_read(32'h010, 5, d, r, lat, stable);
    chk("rd_010_lat", lat, 7);
    chk("rd_010_data", d, 32'hDEADBEEF);
    chk("rd_010_resp", r, 2'b00);
    chk("rd_010_stable", stable, 1'b1);

    do_read(32'hFFC, 0, d, r, lat, stable);
    chk("rd_ffc_data", d, 32'hA4A3A2A1);

    e0 = en_cnt;
    do_read(32'h2000, 2, d, r, lat, stable);
`ifdef AXIL_MEM_BRIDGE_ADDR_CHECK_EN
    chk("rd_2000_resp", r, 2'b10);
    chk("rd_2000_data", d, 32'h0);
    chk("rd_2000_en_cnt", en_cnt - e0, 0);
`else
    chk("rd_2000_resp", r, 2'b00);
    chk("rd_2000_data", d, 32'h04030201);
    chk("rd_2000_en_cnt", en_cnt - e0, 4);
`endif

    @(negedge clk);
    s_awaddr = 32'h030; s_awvalid = 1'b1; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 32'h030; s_arvalid = 1'b1;
    #1;
    chk("prio_ar_blocked", s_arready, 1'b0);
    chk("prio_aw_w_ready", {s_awready, s_wready}, 2'b11);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    ar_seen = 0;
    n = 0;
    while (!s_bvalid && n < 60) begin #1; if (s_arready) ar_seen = 1; @(negedge clk); n++; end
    chk("prio_bvalid", s_bvalid, 1'b1);
    repeat (3) begin #1; if (s_arready) ar_seen = 1; @(negedge clk); end
    chk("prio_no_ar_during_wr", ar_seen, 1'b0);
    chk("prio_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk("prio_ar_after_b", s_arready, 1'b1);
    s_arvalid = 1'b0;
    do_read(32'h030, 0, d, r, lat, stable);
    chk("prio_rd_data", d, 32'hCAFEF00D);

    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 32'h010;
    hs = 0;
    for (int k = 0; k < 60 && !hs; k++) begin #1; hs = s_arready; @(negedge clk); end
    s_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_byte2_addr", mem_addr, 64'h12);
    chk("rst_byte2_en", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
                         s_rdata, mem_en, mem_we, mem_din}, 64'd0);
    @(negedge clk);
    chk("rst_mid_addr", mem_addr, 64'd0);
    rst = 1'b0;
    rv_seen = 0;
    repeat (12) begin @(negedge clk); if (s_rvalid || mem_en) rv_seen = 1; end
    chk("rst_no_resp", rv_seen, 1'b0);
    do_read(32'h010, 0, d, r, lat, stable);
    chk("rst_rd_lat", lat, 7);
    chk("rst_rd_data", d, 32'hDEADBEEF);

    w0 = wr_cnt;
`ifdef AXIL_MEM_BRIDGE_ADDR_CHECK_EN
    do_write("wr_2010_bresp", 32'h2010, 32'h0BADF00D, 4'hF, 0, 2'b10);
    chk("wr_2010_cnt", wr_cnt - w0, 0);
    do_read(32'h010, 0, d, r, lat, stable);
    chk("wr_2010_alias", d, 32'hDEADBEEF);
`else
    do_write("wr_2010_bresp", 32'h2010, 32'h0BADF00D, 4'hF, 0, 2'b00);
    chk("wr_2010_cnt", wr_cnt - w0, 4);
    do_read(32'h010, 0, d, r, lat, stable);
    chk("wr_2010_alias", d, 32'h0BADF00D);
`endif
    chk("addr_window", hi_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
